// File: rtl/psum_pkg.sv
// Shared constants, FSM state and result record for the partial-product accumulator.
package psum_pkg;

  localparam int IN_W_DEF    = 16;
  localparam int ACC_W_DEF   = 24;
  localparam int WIN_LEN_DEF = 9;
  localparam int CNT_W_DEF   = $clog2(WIN_LEN_DEF + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Result record at the default widths.
  typedef struct packed {
    logic [ACC_W_DEF-1:0] data;
    logic                 ovf;
    logic [CNT_W_DEF-1:0] cnt;
  } result_t;

endpackage

// File: rtl/psum_out_reg.sv
// Valid/ready result register for psum_accum; produces in_rdy.
// Optional ReLU clamp on the loaded data when PSUM_RELU_EN is defined.
module psum_out_reg
  import psum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ACC_W-1:0] load_data,
  input  logic             load_ovf,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             out_rdy,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  logic [ACC_W-1:0] load_val;

`ifdef PSUM_RELU_EN
  assign load_val = load_data[ACC_W-1] ? '0 : load_data;
`else
  assign load_val = load_data;
`endif

  // Handshake: a result transfers on out_vld & out_rdy; the upstream may
  // only present a beat when the register is empty or draining this cycle.
  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_cnt  <= '0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_data <= load_val;
      out_ovf  <= load_ovf;
      out_cnt  <= load_cnt;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Window accumulator for signed partial products from the shift-add multiplier.
// Define PSUM_RELU_EN to clamp negative window results to zero.
module psum_accum
  import psum_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  localparam int CNT_W  = $clog2(WIN_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pp_vld,
  input  logic signed [IN_W-1:0]  pp_data,
  input  logic                    pp_last,
  input  logic                    flush,
  output logic                    in_rdy,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf,
  output logic [CNT_W-1:0]        out_cnt,
  output state_t                  dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] ext, sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat, ignore, take, term, close, ovf_now, ovf_acc;

  assign ext     = {{(ACC_W-IN_W){pp_data[IN_W-1]}}, pp_data};
  assign sum     = pp_vld ? acc_q + ext : acc_q;
  assign ovf_now = pp_vld & (acc_q[ACC_W-1] == ext[ACC_W-1]) & (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign ovf_acc = ovf_q | ovf_now;
  assign cnt_inc = cnt_q + CNT_W'(pp_last);

  // A lone flush with nothing accumulated is a no-op, not an empty window.
  assign beat   = (pp_vld | pp_last | flush) & in_rdy;
  assign ignore = flush & ~pp_vld & ~pp_last & (state_q == IDLE);
  assign take   = beat & ~ignore;
  assign term   = pp_last & (cnt_q == LAST_IDX);
  assign close  = take & (term | flush);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (take) begin
      if (close) begin
        state_d = IDLE;
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum;
        ovf_d   = ovf_acc;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

  psum_out_reg #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (close),
    .load_data(sum),
    .load_ovf (ovf_acc),
    .load_cnt (cnt_inc),
    .out_rdy  (out_rdy),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_cnt  (out_cnt)
  );

endmodule
